bounded_always_monitor: RTL and testbench
=========================================

# bounded_always_monitor

Synthesizable runtime checker for `always [LO:HI] a` / `s_always [LO:HI] a` / `always [LO:$] a` property semantics. Sits downstream of the stimulus/reset sequencing logic in the assertion test harness: consumes trigger and checked signals each clock and produces registered pass/fail pulses and counters. Gives formal and simulation flows a cross-check against native SVA evaluation.

## Interface
- `LO`, 2, first cycle offset (after trigger) at which `a` must hold; ≥0
- `HI`, 5, last cycle offset; `HI ≥ LO`; ignored when `UNBOUNDED=1`
- `UNBOUNDED`, 0, 1 = window `[LO:$]`
- `STRONG`, 0, 1 = strong (s_always) semantics; `STRONG=1` with `UNBOUNDED=1` is illegal (elaboration error)
- `CW`, 16, counter width
- `clk` input 1 sole clock, rising edge
- `reset` input 1 asynchronous, active-low; low clears all state immediately
- `en` input 1 attempt trigger, sampled each edge
- `a` input 1 checked signal
- `eot` input 1 end-of-trace pulse
- `pass` output 1 one-cycle pulse, ≥1 attempt passed
- `fail` output 1 one-cycle pulse, ≥1 attempt failed
- `active` output 1 any attempt pending or armed
- `pass_count` output CW saturating count of passed attempts
- `fail_count` output CW saturating count of failed attempts

## Operation
- Attempt starts at edge t when `en=1` (age 0). At edges t+k, k∈[LO,HI], `a` must be 1.
- Bounded mode: one pending bit per age 0..HI in a shift register; bit advances one age per edge.
  - Age in [LO,HI] and `a=0`: bit killed, counted as failure.
  - Bit reaching age HI with `a=1`: counted as pass, retired.
  - `LO=0`: `a` checked at the trigger edge itself.
- Unbounded mode: bits for ages 0..LO-1 as above; on reaching age LO the bit merges into sticky `armed` flag (multiple attempts collapse into one). While armed, `a=0` → one failure (counted as the number of merged attempts, tracked in a CW-bit saturating `armed_n`), armed cleared. Never passes except at `eot`.
- `eot` at edge e (evaluation at e is performed first):
  - Weak: all surviving pending bits and `armed` counted as pass.
  - Strong: surviving pending bits with incomplete window counted as fail.
  - All state cleared; `en` at edge e ignored.
- Per edge, counters add population count of passes/fails (up to HI+1 each), saturating at 2^CW−1.
- Simultaneous pass and fail from different attempts: both pulses assert.

## Timing
- Reset values: `pass=0`, `fail=0`, `active=0`, counters 0, pending/armed cleared.
- All outputs registered: decision at edge t+k visible in the cycle after that edge (latency 1 from sampling edge).
- `active` reflects state after the edge (high from the edge after trigger; still low at trigger edge when `LO=HI=0` pass/fail immediately).
- Reset mid-attempt: attempts discarded, no pass/fail reported, counters zeroed.
- `en` every cycle: up to HI+1 concurrent attempts, no loss.

## Structure
- Package `bam_pkg`: `age_w(HI)` function (`$clog2(HI+1)`), `popcount` function, saturating-add function, `bam_mode_e` enum {WEAK_BOUNDED, STRONG_BOUNDED, WEAK_UNBOUNDED}.
- Sub-module `bam_attempt_shreg`: pending shift register with per-age kill mask and retire output; top holds armed logic, eot handling, counters, parameter legality checks.

## Test plan
- LO=2,HI=5: `en` at edge 0, `a=1` edges 2–5 → `pass` pulse after edge 5, pass_count=1.
- LO=2,HI=5: `en` edge 0, `a=0` at edge 3 only → `fail` after edge 3, nothing after edge 5, fail_count=1.
- `en` edges 0 and 1, `a=0` at edge 5 → both attempts fail in one cycle, fail_count=2; attempt from edge 1 does not pass later.
- STRONG=1: `en` edge 0, `eot` edge 3 → fail_count=1; same with STRONG=0 → pass_count=1.
- UNBOUNDED=1,LO=2: `en` edge 0, `a=1` edges 2–20, `a=0` edge 21 → single `fail` after edge 21; alt. `eot` edge 10 → pass.
- Reset low at edge 3 of a live attempt → all outputs 0 immediately; no pulse after release.

Source files
------------

// File: rtl/bam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bam_pkg
// Brief    : Shared types and helpers for the bounded-always property monitor.
// Revision : 1.0 - initial release
// ============================================================================
package bam_pkg;

    localparam int c_max_ages = 64;

    typedef enum logic [1:0] {
        WEAK_BOUNDED   = 2'd0,
        STRONG_BOUNDED = 2'd1,
        WEAK_UNBOUNDED = 2'd2
    } bam_mode_e;

    // Bits needed to hold an age index 0..hi (never narrower than one bit).
    function automatic int age_w(input int hi);
        return (hi < 1) ? 1 : $clog2(hi + 1);
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int          cw);
        logic [63:0] lim;
        logic [63:0] sum;
        lim = (64'd1 << cw) - 64'd1;
        sum = acc + inc;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bounded_always_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : bounded_always_monitor_if
// Brief    : Trigger/check inputs and verdict outputs of the property monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface bounded_always_monitor_if #(
    parameter int CW = 16
) ();

    logic          en;
    logic          a;
    logic          eot;
    logic          pass;
    logic          fail;
    logic          active;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;

    modport master (
        output en, a, eot,
        input  pass, fail, active, pass_count, fail_count
    );

    modport slave (
        input  en, a, eot,
        output pass, fail, active, pass_count, fail_count
    );

endinterface
`default_nettype wire

// File: rtl/bam_attempt_shreg.sv
`default_nettype none
// ============================================================================
// Module   : bam_attempt_shreg
// Brief    : One pending bit per attempt age; kills bits whose window sees a=0.
// Revision : 1.0 - initial release
// ============================================================================
module bam_attempt_shreg
    import bam_pkg::*;
#(
    parameter int AGES = 6,
    parameter int LO   = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_start,
    input  wire logic            i_a,
    input  wire logic            i_clear,
    output logic [AGES-1:0]      o_kill,
    output logic                 o_exit,
    output logic [AGES-1:0]      o_live
);

    logic [AGES-1:0] w_age;
    logic [AGES-1:0] w_surv;

    assign w_age[0] = i_start;
    assign w_surv   = w_age & ~o_kill;
    // The oldest slot never stores; its survivor leaves through o_exit.
    assign o_exit   = w_surv[AGES-1];

    for (genvar k = 0; k < AGES; k++) begin : g_age
        if (k >= LO) begin : g_chk
            assign o_kill[k] = w_age[k] & ~i_a;
        end else begin : g_free
            assign o_kill[k] = 1'b0;
        end

        if (k < AGES - 1) begin : g_stage
            logic r_bit;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_bit <= 1'b0;
                end else begin
                    r_bit <= w_surv[k] & ~i_clear;
                end
            end
            assign w_age[k+1] = r_bit;
            assign o_live[k]  = w_surv[k];
        end else begin : g_last
            assign o_live[k] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bounded_always_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bounded_always_monitor
// Brief    : Runtime checker for always/s_always [LO:HI] and always [LO:$].
// Revision : 1.0 - initial release
// ============================================================================
module bounded_always_monitor
    import bam_pkg::*;
#(
    parameter int LO        = 2,
    parameter int HI        = 5,
    parameter int UNBOUNDED = 0,
    parameter int STRONG    = 0,
    parameter int CW        = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    bounded_always_monitor_if.slave   bus
);

    localparam int        c_ages  = (UNBOUNDED != 0) ? LO + 1 : HI + 1;
    localparam int        c_cnt_w = age_w(c_ages - 1) + 1;
    localparam bam_mode_e c_mode  = (UNBOUNDED != 0) ? WEAK_UNBOUNDED :
                                    ((STRONG != 0) ? STRONG_BOUNDED : WEAK_BOUNDED);

    if ((STRONG != 0) && (UNBOUNDED != 0)) begin : g_bad_mode
        $error("bounded_always_monitor: STRONG=1 with UNBOUNDED=1 is illegal");
    end
    if ((LO < 0) || ((UNBOUNDED == 0) && (HI < LO))) begin : g_bad_window
        $error("bounded_always_monitor: window needs 0 <= LO <= HI");
    end
    if (c_ages > c_max_ages) begin : g_bad_depth
        $error("bounded_always_monitor: window deeper than 64 ages");
    end
    if ((CW < 1) || (CW > 62)) begin : g_bad_cw
        $error("bounded_always_monitor: CW must be within 1..62");
    end

    logic                w_start;
    logic [c_ages-1:0]   w_kill;
    logic [c_ages-1:0]   w_live;
    logic                w_exit;
    logic [c_cnt_w-1:0]  w_pop_kill;
    logic [c_cnt_w-1:0]  w_pop_live;
    logic [63:0]         w_pass_n;
    logic [63:0]         w_fail_n;
    logic                w_arm_next;
    logic [CW-1:0]       w_armn_next;
    logic [CW-1:0]       w_pc_next;
    logic [CW-1:0]       w_fc_next;

    logic                r_armed;
    logic [CW-1:0]       r_armed_n;
    logic                r_pass;
    logic                r_fail;
    logic                r_active;
    logic [CW-1:0]       r_pass_count;
    logic [CW-1:0]       r_fail_count;

    // A trigger coinciding with end-of-trace never starts an attempt.
    assign w_start = bus.en & ~bus.eot;

    bam_attempt_shreg #(
        .AGES (c_ages),
        .LO   (LO)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_a     (bus.a),
        .i_clear (bus.eot),
        .o_kill  (w_kill),
        .o_exit  (w_exit),
        .o_live  (w_live)
    );

    assign w_pop_kill = c_cnt_w'(popcount(64'(w_kill)));
    assign w_pop_live = c_cnt_w'(popcount(64'(w_live)));

    always_comb begin
        w_pass_n    = 64'd0;
        w_fail_n    = 64'(w_pop_kill);
        w_arm_next  = 1'b0;
        w_armn_next = '0;
        if (c_mode == WEAK_UNBOUNDED) begin
            // Attempts past LO collapse into one armed flag carrying their count.
            if (r_armed && !bus.a) begin
                w_fail_n = w_fail_n + 64'(r_armed_n);
            end
            w_arm_next  = (r_armed & bus.a) | w_exit;
            w_armn_next = CW'(sat_add((r_armed && bus.a) ? 64'(r_armed_n) : 64'd0,
                                      64'(w_exit), CW));
            if (bus.eot) begin
                w_pass_n = 64'(w_pop_live) + (w_arm_next ? 64'(w_armn_next) : 64'd0);
            end
        end else if (c_mode == STRONG_BOUNDED) begin
            w_pass_n = 64'(w_exit);
            if (bus.eot) begin
                w_fail_n = w_fail_n + 64'(w_pop_live);
            end
        end else begin
            w_pass_n = 64'(w_exit);
            if (bus.eot) begin
                w_pass_n = w_pass_n + 64'(w_pop_live);
            end
        end
        w_pc_next = CW'(sat_add(64'(r_pass_count), w_pass_n, CW));
        w_fc_next = CW'(sat_add(64'(r_fail_count), w_fail_n, CW));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed      <= 1'b0;
            r_armed_n    <= '0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_active     <= 1'b0;
            r_pass_count <= '0;
            r_fail_count <= '0;
        end else begin
            r_armed      <= w_arm_next & ~bus.eot;
            r_armed_n    <= bus.eot ? '0 : w_armn_next;
            r_pass       <= |w_pass_n;
            r_fail       <= |w_fail_n;
            r_active     <= ~bus.eot & ((|w_live) | w_arm_next);
            r_pass_count <= w_pc_next;
            r_fail_count <= w_fc_next;
        end
    end

    assign bus.pass       = r_pass;
    assign bus.fail       = r_fail;
    assign bus.active     = r_active;
    assign bus.pass_count = r_pass_count;
    assign bus.fail_count = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_bounded_always_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bounded_always_monitor
// Brief    : Directed vector bench for weak/strong/unbounded monitor variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounded_always_monitor;

    typedef struct {
        int en;
        int a;
        int eot;
        int p;
        int f;
        int act;
        int pc;
        int fc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic a;
    logic eot;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bounded_always_monitor_if #(.CW(16)) bus0 ();
    bounded_always_monitor_if #(.CW(16)) bus1 ();
    bounded_always_monitor_if #(.CW(16)) bus2 ();
    bounded_always_monitor_if #(.CW(2))  bus3 ();

    assign bus0.en = en;  assign bus0.a = a;  assign bus0.eot = eot;
    assign bus1.en = en;  assign bus1.a = a;  assign bus1.eot = eot;
    assign bus2.en = en;  assign bus2.a = a;  assign bus2.eot = eot;
    assign bus3.en = en;  assign bus3.a = a;  assign bus3.eot = eot;

    bounded_always_monitor #(.LO(2), .HI(5), .UNBOUNDED(0), .STRONG(0), .CW(16))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    bounded_always_monitor #(.LO(2), .HI(5), .UNBOUNDED(0), .STRONG(1), .CW(16))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    bounded_always_monitor #(.LO(2), .HI(5), .UNBOUNDED(1), .STRONG(0), .CW(16))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));
    bounded_always_monitor #(.LO(0), .HI(0), .UNBOUNDED(0), .STRONG(0), .CW(2))
        dut3 (.clk(clk), .reset(reset), .bus(bus3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic aa, input logic ee);
        @(negedge clk);
        en  = e;
        a   = aa;
        eot = ee;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input int e, input int aa, input int ee,
                       input int p, input int f, input int act, input int pc, input int fc);
        vec_t v;
        v.en = e;  v.a = aa;  v.eot = ee;
        v.p  = p;  v.f = f;   v.act = act;  v.pc = pc;  v.fc = fc;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // Weak LO=2,HI=5 expectations, one row per clock edge.
        //  n  en a eot | pass fail act pc fc
        add(1, 1, 1, 0,   0, 0, 1, 0, 0);   // e0 trigger
        add(4, 0, 1, 0,   0, 0, 1, 0, 0);   // e1-e4
        add(1, 0, 1, 0,   1, 0, 0, 1, 0);   // e5 window complete
        add(1, 0, 0, 0,   0, 0, 0, 1, 0);   // e6 idle
        add(1, 1, 1, 0,   0, 0, 1, 1, 0);   // e7 trigger
        add(2, 0, 1, 0,   0, 0, 1, 1, 0);   // e8-e9
        add(1, 0, 0, 0,   0, 1, 0, 1, 1);   // e10 a=0 at age 3
        add(2, 0, 1, 0,   0, 0, 0, 1, 1);   // e11-e12 no late pass
        add(2, 1, 1, 0,   0, 0, 1, 1, 1);   // e13-e14 two triggers
        add(3, 0, 1, 0,   0, 0, 1, 1, 1);   // e15-e17
        add(1, 0, 0, 0,   0, 1, 0, 1, 3);   // e18 both killed together
        add(2, 0, 1, 0,   0, 0, 0, 1, 3);   // e19-e20
        add(1, 1, 1, 0,   0, 0, 1, 1, 3);   // e21 trigger
        add(2, 0, 1, 0,   0, 0, 1, 1, 3);   // e22-e23
        add(1, 0, 1, 1,   1, 0, 0, 2, 3);   // e24 eot: weak pass
        add(1, 0, 0, 0,   0, 0, 0, 2, 3);   // e25
        add(1, 1, 1, 1,   0, 0, 0, 2, 3);   // e26 en during eot ignored
        add(1, 0, 1, 0,   0, 0, 0, 2, 3);   // e27
        add(5, 1, 1, 0,   0, 0, 1, 2, 3);   // e28-e32 back-to-back
        add(1, 1, 1, 0,   1, 0, 1, 3, 3);   // e33
        add(1, 0, 1, 0,   1, 0, 1, 4, 3);   // e34
        add(1, 0, 1, 0,   1, 0, 1, 5, 3);   // e35
        add(1, 0, 1, 0,   1, 0, 1, 6, 3);   // e36
        add(1, 0, 1, 0,   1, 0, 1, 7, 3);   // e37
        add(1, 0, 1, 0,   1, 0, 0, 8, 3);   // e38 last retire
        add(1, 0, 0, 0,   0, 0, 0, 8, 3);   // e39
        add(1, 1, 1, 0,   0, 0, 1, 8, 3);   // e40 attempt X
        add(2, 0, 1, 0,   0, 0, 1, 8, 3);   // e41-e42
        add(1, 1, 1, 0,   0, 0, 1, 8, 3);   // e43 attempt Y
        add(1, 0, 0, 1,   1, 1, 0, 9, 4);   // e44 X fails, Y passes at eot

        reset = 1'b0;
        en    = 1'b0;
        a     = 1'b0;
        eot   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.pass",   64'(bus0.pass),       64'd0);
        chk("reset.fail",   64'(bus0.fail),       64'd0);
        chk("reset.active", 64'(bus0.active),     64'd0);
        chk("reset.pc",     64'(bus0.pass_count), 64'd0);
        chk("reset.fc",     64'(bus0.fail_count), 64'd0);
        chk("reset.u_act",  64'(bus2.active),     64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en != 0, vecs[i].a != 0, vecs[i].eot != 0);
            chk($sformatf("row%0d.pass", i),   64'(bus0.pass),       64'(vecs[i].p));
            chk($sformatf("row%0d.fail", i),   64'(bus0.fail),       64'(vecs[i].f));
            chk($sformatf("row%0d.active", i), 64'(bus0.active),     64'(vecs[i].act));
            chk($sformatf("row%0d.pc", i),     64'(bus0.pass_count), 64'(vecs[i].pc));
            chk($sformatf("row%0d.fc", i),     64'(bus0.fail_count), 64'(vecs[i].fc));
        end
        // Strong variant saw the same trace: eot survivors become failures.
        chk("strong.pc", 64'(bus1.pass_count), 64'd7);
        chk("strong.fc", 64'(bus1.fail_count), 64'd6);

        @(negedge clk);
        en = 1'b0;  a = 1'b0;  eot = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rst.pc",  64'(bus0.pass_count), 64'd0);
        chk("async_rst.fc",  64'(bus0.fail_count), 64'd0);
        chk("async_rst.sfc", 64'(bus1.fail_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Unbounded LO=2: a single attempt armed until a drops at edge 21.
        step(1'b1, 1'b1, 1'b0);
        chk("unb.act0",    64'(bus2.active), 64'd1);
        chk("unb.pass0",   64'(bus2.pass),   64'd0);
        chk("lo0.pass",    64'(bus3.pass),   64'd1);
        chk("lo0.active",  64'(bus3.active), 64'd0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("unb.nofail%0d", i), 64'(bus2.fail), 64'd0);
        end
        chk("unb.act20",  64'(bus2.active),     64'd1);
        chk("unb.pc20",   64'(bus2.pass_count), 64'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("unb.fail21", 64'(bus2.fail),       64'd1);
        chk("unb.fc21",   64'(bus2.fail_count), 64'd1);
        chk("unb.act21",  64'(bus2.active),     64'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("unb.fail22", 64'(bus2.fail),       64'd0);

        // Two merged armed attempts released by a weak end-of-trace.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        chk("unb_eot.act9", 64'(bus2.active),     64'd1);
        chk("unb_eot.pc9",  64'(bus2.pass_count), 64'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("unb_eot.pass", 64'(bus2.pass),       64'd1);
        chk("unb_eot.pc",   64'(bus2.pass_count), 64'd2);
        chk("unb_eot.fc",   64'(bus2.fail_count), 64'd1);
        chk("unb_eot.act",  64'(bus2.active),     64'd0);

        // LO=HI=0 decides at the trigger edge; 2-bit counters saturate.
        step(1'b1, 1'b0, 1'b0);
        chk("lo0.fail",    64'(bus3.fail),   64'd1);
        chk("lo0.active2", 64'(bus3.active), 64'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("sat.pass", 64'(bus3.pass),       64'd1);
        chk("sat.pc",   64'(bus3.pass_count), 64'd3);

        // Reset asserted while an attempt is live.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("midrst.live", 64'(bus0.active), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst.active", 64'(bus0.active),     64'd0);
        chk("midrst.pass",   64'(bus0.pass),       64'd0);
        chk("midrst.pc",     64'(bus0.pass_count), 64'd0);
        chk("midrst.upc",    64'(bus2.pass_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("postrst.pass%0d", i),   64'(bus0.pass),   64'd0);
            chk($sformatf("postrst.active%0d", i), 64'(bus0.active), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
